// File: rtl/regfile_nxm_sync.sv
// Parametrised register file: DEPTH x DATA_W storage, one write port and two
// registered read ports, with optional write-to-read bypass and hardwired-zero reg 0.
module regfile_nxm_sync #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              WRITE_EN,
  input  logic [ADDR_W-1:0]                 INaddr,
  input  logic [DATA_W-1:0]                 IN,
  input  logic [ADDR_W-1:0]                 OUT1addr,
  input  logic [ADDR_W-1:0]                 OUT2addr,
  output logic [DATA_W-1:0]                 OUT1,
  output logic [DATA_W-1:0]                 OUT2,
  output logic [DATA_W*(2**ADDR_W)-1:0]     debugPin
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              wr_ok;

  // Writes to register 0 are dropped when it is hardwired to zero.
  assign wr_ok = WRITE_EN && !((ZERO_REG != 0) && (INaddr == '0));

  // Read value before this edge's write; bypass forwards IN, zero reg overrides all.
  always_comb begin
    rd1 = mem[OUT1addr];
    if ((BYPASS != 0) && WRITE_EN && (OUT1addr == INaddr))
      rd1 = IN;
    if ((ZERO_REG != 0) && (OUT1addr == '0))
      rd1 = '0;
  end

  always_comb begin
    rd2 = mem[OUT2addr];
    if ((BYPASS != 0) && WRITE_EN && (OUT2addr == INaddr))
      rd2 = IN;
    if ((ZERO_REG != 0) && (OUT2addr == '0))
      rd2 = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem  <= '{default: '0};
      OUT1 <= '0;
      OUT2 <= '0;
    end else begin
      if (wr_ok)
        mem[INaddr] <= IN;
      OUT1 <= rd1;
      OUT2 <= rd2;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_dbg
    assign debugPin[g*DATA_W +: DATA_W] = mem[g];
  end

endmodule

// File: tb/tb_regfile_nxm_sync.sv
// Scoreboard bench for regfile_nxm_sync: four parameter variants, directed
// vectors followed by a random sweep against a small reference model.
module tb_regfile_nxm_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0, we = 1'b0;
  logic [2:0] ia = '0, a1 = '0, a2 = '0;
  logic [7:0] din = '0;
  logic        d_we = 1'b0;
  logic [3:0]  d_ia = '0, d_a1 = '0, d_a2 = '0;
  logic [15:0] d_din = '0;

  logic [7:0]   a_o1, a_o2, b_o1, b_o2, c_o1, c_o2;
  logic [63:0]  a_dbg, b_dbg, c_dbg;
  logic [15:0]  d_o1, d_o2;
  logic [255:0] d_dbg;

  regfile_nxm_sync #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0)) dut_a (
    .clk(clk), .reset(rst), .WRITE_EN(we), .INaddr(ia), .IN(din),
    .OUT1addr(a1), .OUT2addr(a2), .OUT1(a_o1), .OUT2(a_o2), .debugPin(a_dbg));
  regfile_nxm_sync #(.DATA_W(8), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .reset(rst), .WRITE_EN(we), .INaddr(ia), .IN(din),
    .OUT1addr(a1), .OUT2addr(a2), .OUT1(b_o1), .OUT2(b_o2), .debugPin(b_dbg));
  regfile_nxm_sync #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1)) dut_c (
    .clk(clk), .reset(rst), .WRITE_EN(we), .INaddr(ia), .IN(din),
    .OUT1addr(a1), .OUT2addr(a2), .OUT1(c_o1), .OUT2(c_o2), .debugPin(c_dbg));
  regfile_nxm_sync #(.DATA_W(16), .ADDR_W(4), .BYPASS(1), .ZERO_REG(0)) dut_d (
    .clk(clk), .reset(rst), .WRITE_EN(d_we), .INaddr(d_ia), .IN(d_din),
    .OUT1addr(d_a1), .OUT2addr(d_a2), .OUT1(d_o1), .OUT2(d_o2), .debugPin(d_dbg));

  localparam int unsigned A1 = 0, A2 = 1, AD = 2, B1 = 3, B2 = 4, BD = 5;
  localparam int unsigned C1 = 6, C2 = 7, CD = 8, D1 = 9, D2 = 10, DD = 11;

  typedef struct {
    int unsigned  cyc;
    int unsigned  sel;
    logic [255:0] exp;
    string        name;
  } chk_t;

  chk_t        q[$];
  int unsigned edge_cnt = 0;
  int unsigned total = 0;
  int unsigned bad = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [255:0] actual(int unsigned sel);
    case (sel)
      A1: return {248'b0, a_o1};
      A2: return {248'b0, a_o2};
      AD: return {192'b0, a_dbg};
      B1: return {248'b0, b_o1};
      B2: return {248'b0, b_o2};
      BD: return {192'b0, b_dbg};
      C1: return {248'b0, c_o1};
      C2: return {248'b0, c_o2};
      CD: return {192'b0, c_dbg};
      D1: return {240'b0, d_o1};
      D2: return {240'b0, d_o2};
      default: return d_dbg;
    endcase
  endfunction

  // Expectation for the state visible after the next rising edge.
  task automatic chk(int unsigned sel, logic [255:0] v, string name);
    chk_t c;
    c.cyc = edge_cnt + 1; c.sel = sel; c.exp = v; c.name = name;
    q.push_back(c);
  endtask

  task automatic drive(logic r, logic w, logic [2:0] wa, logic [7:0] d,
                       logic [2:0] r1, logic [2:0] r2);
    @(negedge clk);
    rst = r; we = w; ia = wa; din = d; a1 = r1; a2 = r2;
  endtask

  function automatic logic [255:0] pack8(logic [7:0] m [8]);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = m[i];
    return r;
  endfunction

  // Monitor: outputs are valid every cycle after reset, so it drains due entries each negedge.
  initial begin
    chk_t         c;
    logic [255:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
        c   = q.pop_front();
        act = actual(c.sel);
        total++;
        if (act !== c.exp) begin
          bad++;
          $display("FAIL %s edge=%0d got=%h want=%h", c.name, edge_cnt, act, c.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]   m [8];
    logic [7:0]   mc [8];
    logic [255:0] e;
    logic         r, w;
    logic [2:0]   wa, r1, r2;
    logic [7:0]   d;

    // Reset, fill with FF, reset again with a pending write.
    drive(1, 0, 0, 8'h00, 0, 0);
    chk(AD, 0, "rst0_dbg"); chk(A1, 0, "rst0_o1"); chk(A2, 0, "rst0_o2");
    for (int i = 0; i < 8; i++) drive(0, 1, 3'(i), 8'hFF, 0, 0);
    chk(AD, 64'hFFFF_FFFF_FFFF_FFFF, "fill_a_dbg");
    chk(BD, 64'hFFFF_FFFF_FFFF_FFFF, "fill_b_dbg");
    chk(CD, 64'hFFFF_FFFF_FFFF_FF00, "fill_c_dbg");
    drive(1, 1, 3, 8'h55, 5, 7);
    chk(AD, 0, "rst1_a_dbg"); chk(BD, 0, "rst1_b_dbg"); chk(CD, 0, "rst1_c_dbg");
    chk(A1, 0, "rst1_a_o1"); chk(A2, 0, "rst1_a_o2"); chk(B1, 0, "rst1_b_o1");

    // Write latency and write-enable hold.
    drive(0, 1, 6, 8'hAA, 6, 0);
    chk(A1, 8'hAA, "lat_bypass_a"); chk(B1, 8'h00, "lat_before_b");
    drive(0, 0, 6, 8'h11, 6, 6);
    chk(A1, 8'hAA, "lat_a_o1"); chk(B1, 8'hAA, "lat_b_o1"); chk(B2, 8'hAA, "lat_b_o2");
    drive(0, 0, 0, 8'h00, 6, 0);
    chk(A1, 8'hAA, "hold_a_o1"); chk(AD, 64'h00AA_0000_0000_0000, "hold_a_dbg");

    // Bypass vs. no-bypass, both ports on the written address.
    drive(0, 1, 3, 8'hBB, 0, 0);
    drive(0, 1, 3, 8'hCC, 3, 3);
    chk(A1, 8'hCC, "byp_a_o1"); chk(A2, 8'hCC, "byp_a_o2");
    chk(B1, 8'hBB, "nobyp_b_o1"); chk(B2, 8'hBB, "nobyp_b_o2"); chk(C1, 8'hCC, "byp_c_o1");
    drive(0, 0, 0, 8'h00, 3, 3);
    chk(B1, 8'hCC, "nobyp_b_o1_late"); chk(B2, 8'hCC, "nobyp_b_o2_late");

    // Hardwired zero register.
    drive(0, 1, 0, 8'h7F, 0, 0);
    chk(C1, 0, "zr_c_o1"); chk(C2, 0, "zr_c_o2");
    chk(A1, 8'h7F, "zr_a_o1"); chk(B1, 8'h00, "zr_b_o1");
    drive(0, 1, 1, 8'h7F, 0, 1);
    chk(C1, 0, "zr_c_o1b"); chk(C2, 8'h7F, "zr_c_o2_r1");
    chk(B1, 8'h7F, "zr_b_o1_r0"); chk(B2, 8'h00, "zr_b_o2_old");
    chk(CD, 64'h00AA_0000_CC00_7F00, "zr_c_dbg"); chk(AD, 64'h00AA_0000_CC00_7F7F, "zr_a_dbg");
    drive(0, 0, 0, 8'h00, 1, 0);
    chk(C1, 8'h7F, "zr_c_r1"); chk(C2, 0, "zr_c_r0"); chk(A2, 8'h7F, "zr_a_r0");

    // Mid-stream reset with a write pending.
    drive(1, 1, 2, 8'h99, 1, 3);
    chk(AD, 0, "rst2_a_dbg"); chk(BD, 0, "rst2_b_dbg"); chk(CD, 0, "rst2_c_dbg");
    chk(A1, 0, "rst2_a_o1"); chk(A2, 0, "rst2_a_o2"); chk(C2, 0, "rst2_c_o2");
    drive(0, 0, 0, 8'h00, 2, 0);
    chk(A1, 0, "rst2_discard");

    // Wider variant: 16 x 16.
    drive(0, 0, 0, 8'h00, 0, 0);
    d_we = 1; d_ia = 15; d_din = 16'h1234; d_a1 = 15; d_a2 = 0;
    chk(D1, 16'h1234, "w16_byp");
    drive(0, 0, 0, 8'h00, 0, 0);
    d_we = 1; d_ia = 0; d_din = 16'hABCD; d_a1 = 0; d_a2 = 15;
    chk(D2, 16'h1234, "w16_r15"); chk(D1, 16'hABCD, "w16_r0_byp");
    drive(0, 0, 0, 8'h00, 0, 0);
    d_we = 0; d_a1 = 0; d_a2 = 15;
    e = '0; e[255:240] = 16'h1234; e[15:0] = 16'hABCD;
    chk(D2, 16'h1234, "w16_r15_hold"); chk(D1, 16'hABCD, "w16_r0"); chk(DD, e, "w16_dbg");

    // Random sweep against a reference model.
    for (int i = 0; i < 1000; i++) begin
      r  = (i == 0) || ($urandom_range(0, 39) == 0);
      w  = 1'($urandom_range(0, 1));
      wa = 3'($urandom_range(0, 7));
      d  = 8'($urandom);
      r1 = 3'($urandom_range(0, 7));
      r2 = 3'($urandom_range(0, 7));
      drive(r, w, wa, d, r1, r2);
      if (r) begin
        chk(A1, 0, "rnd_a_o1"); chk(A2, 0, "rnd_a_o2");
        chk(B1, 0, "rnd_b_o1"); chk(B2, 0, "rnd_b_o2");
        chk(C1, 0, "rnd_c_o1"); chk(C2, 0, "rnd_c_o2");
        for (int k = 0; k < 8; k++) begin m[k] = '0; mc[k] = '0; end
      end else begin
        chk(A1, (w && r1 == wa) ? d : m[r1], "rnd_a_o1");
        chk(A2, (w && r2 == wa) ? d : m[r2], "rnd_a_o2");
        chk(B1, m[r1], "rnd_b_o1");
        chk(B2, m[r2], "rnd_b_o2");
        chk(C1, (r1 == 0) ? 8'h00 : (w && r1 == wa) ? d : mc[r1], "rnd_c_o1");
        chk(C2, (r2 == 0) ? 8'h00 : (w && r2 == wa) ? d : mc[r2], "rnd_c_o2");
        if (w) begin
          m[wa] = d;
          if (wa != 0) mc[wa] = d;
        end
      end
      chk(AD, pack8(m), "rnd_a_dbg");
      chk(BD, pack8(m), "rnd_b_dbg");
      chk(CD, pack8(mc), "rnd_c_dbg");
    end

    drive(0, 0, 0, 8'h00, 0, 0);
    drive(0, 0, 0, 8'h00, 0, 0);
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_nxm_sync.md
Name: regfile_nxm_sync

Overview:
- Parametrised successor of the 8x8 processor register file: DEPTH registers of DATA_W bits, two registered read ports and one write port, all on the rising edge of clk.
- Adds write enable, synchronous clear, optional write-to-read bypass and an optional hardwired-zero register 0.
- Sits between the CU (addresses, write enable) and the ALU/operand muxes (OUT1/OUT2 in, IN back from the ALU result).

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers.
- BYPASS, 1, 1 = a read of the address being written this cycle returns the new IN value; 0 = it returns the old stored value.
- ZERO_REG, 0, 1 = register 0 always reads 0 and writes to it are discarded.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; clears all state on the rising edge of clk.
- WRITE_EN  input  1  write strobe for the write port.
- INaddr  input  ADDR_W  write address.
- IN  input  DATA_W  write data.
- OUT1addr  input  ADDR_W  read port 1 address.
- OUT2addr  input  ADDR_W  read port 2 address.
- OUT1  output  DATA_W  registered read data, port 1.
- OUT2  output  DATA_W  registered read data, port 2.
- debugPin  output  DATA_W*DEPTH  flattened register contents; register k occupies bits [k*DATA_W +: DATA_W]; combinational from storage.

Behaviour:
- Reset: reset high at a rising edge clears every register, OUT1 and OUT2 to 0, so debugPin reads all zeros from that edge on.
  - Reset has priority: a write pending on the same edge is discarded.
  - Read addresses presented on the reset edge are ignored.
  - Reset applied mid-stream (after writes) gives the same result.
- Write: at a rising edge with reset=0 and WRITE_EN=1, mem[INaddr] <= IN. With WRITE_EN=0 storage holds.
- Read latency is 1 cycle:
  - At each rising edge with reset=0, OUT1 <= value(OUT1addr) and OUT2 <= value(OUT2addr).
  - The outputs then hold until the next edge.
- Read value rules:
  - If ZERO_REG=1 and the address is 0, the value is 0.
  - Otherwise, if BYPASS=1, WRITE_EN=1 and the address equals INaddr, the value is IN.
  - Otherwise, the value is the stored mem[address] before this edge's write.
- Writes to register 0 when ZERO_REG=1:
  - Storage is untouched (stays 0).
  - debugPin bits [DATA_W-1:0] stay 0.
- Both read ports may address the same register, or the write address, in the same cycle. No conflict or priority issue arises; each port applies the rules above independently.
- Addresses are full-range. Every value 0..DEPTH-1 is valid, with no out-of-range case and no wrap logic.
- Arithmetic: none. Data is stored and returned bit-exact at DATA_W.
- No X propagation from storage after the first reset. Before the first reset, contents are undefined, and the bench must reset first.
- State: storage array, OUT1 register, OUT2 register. There is no FSM; the only sequencing is the 1-cycle read pipeline.

Test Plan:
- Reset: defaults, write 8'hFF to every address, assert reset for 1 edge -> debugPin == 0, OUT1 == OUT2 == 0; a write presented on the reset edge (INaddr=3, IN=8'h55, WRITE_EN=1) leaves reg3 == 0.
- Write/read latency: write 8'hAA to reg6 at edge N; set OUT1addr=6 at edge N+1 -> OUT1 == 8'hAA after edge N+1, not before. With WRITE_EN=0 and IN=8'h11 to reg6 -> reg6 stays 8'hAA.
- Bypass: with reg3=8'hBB, same edge WRITE_EN=1, INaddr=3, IN=8'hCC, OUT1addr=OUT2addr=3 -> with BYPASS=1 both outputs read 8'hCC after the edge; with BYPASS=0 both read 8'hBB, then 8'hCC one cycle later.
- Zero register: ZERO_REG=1, write 8'h7F to reg0 with OUT1addr=0 and BYPASS=1 -> OUT1 == 0 and debugPin[7:0] == 0; write reg1=8'h7F -> reads 8'h7F.
- Parametrisation: DATA_W=16, ADDR_W=4; write 16'h1234 to reg15 and 16'hABCD to reg0 -> debugPin[255:240] == 16'h1234, [15:0] == 16'hABCD, and port-2 reads of reg15 return 16'h1234.
- Random sweep: 1000 cycles of random enables, addresses and data versus a reference model, with reset pulsed at random -> OUT1, OUT2 and debugPin match every cycle.
